// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the single write port of a regfile_clr bank among NUM_REQ
//   requesters (round-robin, one write per cycle) and runs an init sweep
//   that writes INIT_VAL into every entry.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   req           per-requester write request, held until acked
//   req_addr      packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data      packed data, requester i at [i*BITWIDTH +: BITWIDTH]
//   ack           one-cycle pulse per accepted request
//   wr_en         one-hot bank write enable
//   wr_data       shared bank write data (holds last value)
//   addr_err      pulse when an acked request addressed past the bank
//   init_req      start the init sweep (ignored while sweeping)
//   busy          high while sweeping
//   init_done     pulse in the cycle after the final sweep write
module regfile_wr_arbiter #(
    parameter int                  BITWIDTH    = 11,
    parameter int                  NUM_REQ     = 3,
    parameter int                  ADDR_W      = 6,
    parameter int                  NUM_ENTRIES = 40,
    parameter logic [BITWIDTH-1:0] INIT_VAL    = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*BITWIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_ENTRIES-1:0]        wr_en,
    output logic [BITWIDTH-1:0]           wr_data,
    output logic                          addr_err,
    input  logic                          init_req,
    output logic                          busy,
    output logic                          init_done
);

    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // cnt must also reach NUM_ENTRIES, which marks the init_done cycle
    localparam int CW = $clog2(NUM_ENTRIES + 1);
    localparam logic [NUM_ENTRIES-1:0] ENTRY_ONE = NUM_ENTRIES'(1);

    typedef enum logic {IDLE, INIT} state_t;

    state_t              state;
    logic [LW-1:0]       last;
    logic [CW-1:0]       cnt;

    logic [NUM_REQ-1:0]  elig;
    logic                gnt_vld;
    logic [LW-1:0]       gnt_idx;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [BITWIDTH-1:0] gnt_data;

    // The registered ack masks a requester that is still dropping req.
    assign elig = req & ~ack;

    // Round-robin search: offsets are scanned from farthest to nearest so the
    // nearest eligible requester after 'last' overwrites the others.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        gnt_addr = '0;
        gnt_data = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (elig[i] && (i == (int'(last) + k) % NUM_REQ)) begin
                    gnt_vld  = 1'b1;
                    gnt_idx  = LW'(i);
                    gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
                    gnt_data = req_data[i*BITWIDTH +: BITWIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= LW'(NUM_REQ - 1);
            cnt       <= '0;
            ack       <= '0;
            wr_en     <= '0;
            wr_data   <= '0;
            addr_err  <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
        end else begin
            ack       <= '0;
            wr_en     <= '0;
            addr_err  <= 1'b0;
            init_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_req) begin
                        // Entry 0 is written in the very first busy cycle.
                        state   <= INIT;
                        busy    <= 1'b1;
                        wr_en   <= ENTRY_ONE;
                        wr_data <= INIT_VAL;
                        cnt     <= CW'(1);
                    end else if (gnt_vld) begin
                        ack[gnt_idx] <= 1'b1;
                        wr_data      <= gnt_data;
                        last         <= gnt_idx;
                        if (int'(gnt_addr) < NUM_ENTRIES)
                            wr_en <= ENTRY_ONE << gnt_addr;
                        else
                            addr_err <= 1'b1;
                    end
                end
                INIT: begin
                    if (cnt == CW'(NUM_ENTRIES)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        wr_en   <= ENTRY_ONE << cnt;
                        wr_data <= INIT_VAL;
                        cnt     <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a behavioural model and a bank scoreboard.
module tb_regfile_wr_arbiter;

    localparam int BW = 11;
    localparam int NR = 3;
    localparam int AW = 6;
    localparam int NE = 40;
    localparam logic [BW-1:0] IV = 11'h155;

    logic            clk, rst;
    logic [NR-1:0]   req;
    logic [NR*AW-1:0] req_addr;
    logic [NR*BW-1:0] req_data;
    logic [NR-1:0]   ack;
    logic [NE-1:0]   wr_en;
    logic [BW-1:0]   wr_data;
    logic            addr_err, init_req, busy, init_done;

    regfile_wr_arbiter #(
        .BITWIDTH(BW), .NUM_REQ(NR), .ADDR_W(AW), .NUM_ENTRIES(NE), .INIT_VAL(IV)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .wr_en(wr_en), .wr_data(wr_data), .addr_err(addr_err),
        .init_req(init_req), .busy(busy), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Bank driven by the DUT's write port.
    logic [BW-1:0] bank [NE];
    bit tb_clear;
    always @(posedge clk) begin
        for (int e = 0; e < NE; e++) begin
            if (tb_clear) bank[e] <= '0;
            else if (wr_en[e]) bank[e] <= wr_data;
        end
    end

    int checks, failures;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester side
    bit            r_req [NR];
    int            r_addr[NR];
    logic [BW-1:0] r_data[NR];
    bit            r_init;

    // Reference model
    bit            m_init;
    int            m_k;      // sweep writes issued so far
    int            m_last;
    logic [NR-1:0] e_ack;
    int            e_we;     // expected written entry, -1 for none
    logic [BW-1:0] e_wd;
    bit            e_err, e_busy, e_done;
    logic [BW-1:0] m_bank[NE];

    task automatic model_reset();
        m_init = 0; m_k = 0; m_last = NR - 1;
        e_ack = '0; e_we = -1; e_wd = '0;
        e_err = 0; e_busy = 0; e_done = 0;
    endtask

    task automatic model_edge();
        logic [NR-1:0] na;
        int nwe;
        logic [BW-1:0] nwd;
        bit nerr, ndone, nbusy, found;
        if (e_we >= 0) m_bank[e_we] = e_wd;
        na = '0; nwe = -1; nwd = e_wd; nerr = 0; ndone = 0; nbusy = e_busy; found = 0;
        if (m_init) begin
            if (m_k < NE) begin
                nwe = m_k; nwd = IV; m_k++;
            end else begin
                ndone = 1; nbusy = 0; m_init = 0;
            end
        end else if (r_init) begin
            m_init = 1; nbusy = 1; nwe = 0; nwd = IV; m_k = 1;
        end else begin
            for (int k = 1; k <= NR; k++) begin
                int g;
                g = (m_last + k) % NR;
                if (!found && r_req[g] && !e_ack[g]) begin
                    found = 1;
                    na[g] = 1'b1;
                    nwd = r_data[g];
                    if (r_addr[g] < NE) nwe = r_addr[g];
                    else nerr = 1;
                    m_last = g;
                end
            end
        end
        e_ack = na; e_we = nwe; e_wd = nwd; e_err = nerr; e_done = ndone; e_busy = nbusy;
    endtask

    task automatic check_outputs();
        logic [NE-1:0] ew;
        ew = '0;
        if (e_we >= 0) ew[e_we] = 1'b1;
        chk("ack", ack, e_ack);
        chk("wr_en", wr_en, ew);
        chk("wr_data", wr_data, e_wd);
        chk("addr_err", addr_err, e_err);
        chk("busy", busy, e_busy);
        chk("init_done", init_done, e_done);
        chk("onehot", ($countones(wr_en) <= 1), 1);
    endtask

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            req[i] = r_req[i];
            req_addr[i*AW +: AW] = AW'(r_addr[i]);
            req_data[i*BW +: BW] = r_data[i];
        end
        init_req = r_init;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic new_req(input int i, input bit allow_bad);
        r_req[i]  = 1;
        r_data[i] = BW'($urandom);
        if (allow_bad && ($urandom % 100 < 10)) r_addr[i] = $urandom_range(NE, 63);
        else r_addr[i] = $urandom_range(0, NE - 1);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) begin
            r_req[i] = 0; r_addr[i] = 0; r_data[i] = '0;
        end
        r_init = 0;
    endtask

    task automatic rand_drive(input int init_pct);
        for (int i = 0; i < NR; i++) begin
            if (e_ack[i]) begin
                if ($urandom % 2 == 1) new_req(i, 1);
                else r_req[i] = 0;
            end else if (!r_req[i] && ($urandom % 100 < 40)) begin
                new_req(i, 1);
            end
        end
        r_init = ($urandom % 100 < init_pct);
        apply();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        checks = 0; failures = 0;
        clk = 0; rst = 1; tb_clear = 1;
        clear_reqs(); apply(); model_reset();
        for (int e = 0; e < NE; e++) m_bank[e] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_init_done", init_done, 0);
        rst = 0; tb_clear = 0;

        // Single request from requester 0
        r_req[0] = 1; r_addr[0] = 5; r_data[0] = 11'h2A5; apply();
        cycle();
        chk("t1_ack", ack, 3'b001);
        chk("t1_wr_en", wr_en, 64'd1 << 5);
        chk("t1_wr_data", wr_data, 11'h2A5);
        r_req[0] = 0; apply();
        cycle();
        chk("t1_bank5", bank[5], 11'h2A5);

        // Round-robin with all requesters continuously requesting (last grant was 0)
        for (int i = 0; i < NR; i++) new_req(i, 0);
        apply();
        for (int c = 0; c < 9; c++) begin
            cycle();
            chk("rr_seq", ack, 3'b001 << ((1 + c) % 3));
            for (int i = 0; i < NR; i++) if (e_ack[i]) new_req(i, 0);
            apply();
        end
        clear_reqs(); apply();
        cycle();

        // Out-of-range address
        r_req[1] = 1; r_addr[1] = 45; r_data[1] = 11'h7FF; apply();
        cycle();
        chk("oor_ack", ack, 3'b010);
        chk("oor_err", addr_err, 1);
        chk("oor_wr_en", wr_en, 0);
        r_req[1] = 0; apply();
        cycle();

        // Init sweep with a pending request from requester 2
        r_init = 1; r_req[2] = 1; r_addr[2] = 3; r_data[2] = 11'h3C3; apply();
        cycle();
        r_init = 0; apply();
        chk("init_busy0", busy, 1);
        chk("init_ack0", ack, 0);
        nb = 1;
        for (int c = 0; c < 100 && !init_done; c++) begin
            cycle();
            if (busy) nb++;
        end
        chk("init_done_seen", init_done, 1);
        chk("init_busy_len", nb, NE);
        cycle();
        chk("init_pend_ack", ack, 3'b100);
        chk("init_pend_wr_en", wr_en, 64'd1 << 3);
        r_req[2] = 0; apply();
        cycle();
        chk("init_bank3", bank[3], 11'h3C3);
        chk("init_bank0", bank[0], IV);
        chk("init_bank39", bank[NE-1], IV);

        // Asynchronous reset in cycle 10 of a sweep
        r_init = 1; apply();
        cycle();
        r_init = 0; apply();
        repeat (9) cycle();
        #3; rst = 1; #1;
        chk("arst_ack", ack, 0);
        chk("arst_wr_en", wr_en, 0);
        chk("arst_wr_data", wr_data, 0);
        chk("arst_addr_err", addr_err, 0);
        chk("arst_busy", busy, 0);
        chk("arst_init_done", init_done, 0);
        model_reset(); clear_reqs(); apply();
        @(posedge clk); @(posedge clk);
        #1; rst = 0;
        repeat (3) cycle();
        chk("arst_idle_busy", busy, 0);
        // FSM is idle: a request is granted right away
        r_req[0] = 1; r_addr[0] = 7; r_data[0] = 11'h0AB; apply();
        cycle();
        chk("arst_idle_ack", ack, 3'b001);
        r_req[0] = 0; apply();
        cycle();

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            rand_drive(2);
            cycle();
        end

        // Drain and compare bank contents
        clear_reqs(); apply();
        for (int c = 0; c < 60; c++) cycle();
        for (int e = 0; e < NE; e++) chk("bank", bank[e], m_bank[e]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
